// File: rtl/ieee754_mul_pipe.sv
// ----------------------------------------------------------------------------
// ieee754_mul_pipe
//   Three-stage pipelined IEEE-754 binary multiplier with flush-to-zero.
//     S1  unpack operands and classify the special-case result
//     S2  integer mantissa product and signed unbiased exponent sum
//     S3  normalise, round (optional), detect overflow/underflow, pack
//   All stages advance together whenever the output register is empty or
//   being drained; otherwise the whole pipeline holds.
//
// Configuration macro:
//   IEEE754_MUL_ROUND_EN  defined   -> round-to-nearest-even (guard/round/sticky)
//                         undefined -> truncate toward zero, no rounding logic
//
// Parameters:
//   EXP_W  exponent field width (default 8)
//   MAN_W  stored mantissa field width (default 23); word width W = 1+EXP_W+MAN_W
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand pair a/b valid
//   in_ready   operand pair accepted this cycle when in_valid is also high
//   a, b       IEEE-754 operands (W bits)
//   out_valid  s and flags valid
//   out_ready  downstream accepts the result
//   s          product a*b (W bits)
//   OUVERFLOW  finite operands rounded to +/-Inf
//   UNDERFLOW  nonzero finite operands flushed to +/-0
//   INVALID    0*Inf; canonical NaN returned
// ----------------------------------------------------------------------------
module ieee754_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   s,
  output logic                   OUVERFLOW,
  output logic                   UNDERFLOW,
  output logic                   INVALID
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int EW2 = EXP_W + 2;        // signed exponent width, never wraps
  localparam int PW  = 2 * MAN_W + 2;    // full product of two (MAN_W+1)-bit mantissas

  localparam logic signed [EW2-1:0] BIAS    = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EXP_TOP = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EXP_LOW = '0;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Result class decided in S1; only K_NORM needs the arithmetic path.
  typedef enum logic [2:0] {
    K_NORM,
    K_ZERO,
    K_INF,
    K_QNAN,
    K_INVAL
  } kind_e;

  // --------------------------------------------------------------------------
  // Global advance: every stage moves when the output slot is free or drains.
  // --------------------------------------------------------------------------
  logic advance;

  assign advance  = !out_valid || out_ready;
  // Reset forces readiness so the upstream never sees a stall while the
  // pipeline is being flushed.
  assign in_ready = advance || !rst_n;

  // --------------------------------------------------------------------------
  // S1: unpack and classify
  // --------------------------------------------------------------------------
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  kind_e            kind_c;

  assign {sign_a, exp_a, frac_a} = a;
  assign {sign_b, exp_b, frac_b} = b;

  assign nan_a  = (&exp_a) && (|frac_a);
  assign nan_b  = (&exp_b) && (|frac_b);
  assign inf_a  = (&exp_a) && !(|frac_a);
  assign inf_b  = (&exp_b) && !(|frac_b);
  // A zero exponent field covers both true zero and subnormals (FTZ).
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    kind_c = K_NORM;
    if (nan_a || nan_b)
      kind_c = K_QNAN;
    else if ((inf_a && zero_b) || (inf_b && zero_a))
      kind_c = K_INVAL;
    else if (inf_a || inf_b)
      kind_c = K_INF;
    else if (zero_a || zero_b)
      kind_c = K_ZERO;
  end

  logic             v1;
  kind_e            kind1;
  logic             sign1;
  logic [EXP_W-1:0] exp_a1, exp_b1;
  logic [MAN_W:0]   man_a1, man_b1;

  // --------------------------------------------------------------------------
  // S2: mantissa product and exponent sum
  // --------------------------------------------------------------------------
  logic                  v2;
  kind_e                 kind2;
  logic                  sign2;
  logic signed [EW2-1:0] exp2;
  logic [PW-1:0]         prod2;

  // --------------------------------------------------------------------------
  // S3 combinational: normalise, round, range-check, pack
  // --------------------------------------------------------------------------
  logic                  lead;
  logic [PW-1:0]         norm;
  logic signed [EW2-1:0] exp_n, exp_r;
  logic [MAN_W-1:0]      frac_t, frac_r;
  logic                  unused_lead;

  // Product of two values in [1,2) lies in [1,4): at most one left shift
  // puts the leading one at the top bit.
  assign lead        = prod2[PW-1];
  assign norm        = lead ? prod2 : (prod2 << 1);
  assign exp_n       = exp2 + $signed({{(EW2-1){1'b0}}, lead});
  assign frac_t      = norm[PW-2 -: MAN_W];
  assign unused_lead = norm[PW-1];

`ifdef IEEE754_MUL_ROUND_EN
  logic           guard, rnd, sticky, round_up;
  logic [MAN_W:0] frac_sum;

  assign guard    = norm[MAN_W];
  assign rnd      = norm[MAN_W-1];
  assign sticky   = |norm[MAN_W-2:0];
  // Nearest-even: round up above half, or at exactly half when LSB is odd.
  assign round_up = guard && (rnd || sticky || frac_t[0]);
  assign frac_sum = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
  // A carry out means 1.11..1 became 10.00..0: the low bits are already
  // zero, so renormalising is only the exponent increment.
  assign frac_r   = frac_sum[MAN_W-1:0];
  assign exp_r    = exp_n + $signed({{(EW2-1){1'b0}}, frac_sum[MAN_W]});
`else
  logic unused_tail;

  assign unused_tail = ^norm[MAN_W:0];
  assign frac_r      = frac_t;
  assign exp_r       = exp_n;
`endif

  logic [W-1:0] s_c;
  logic         ovf_c, udf_c, inv_c;

  always_comb begin
    s_c   = '0;
    ovf_c = 1'b0;
    udf_c = 1'b0;
    inv_c = 1'b0;
    unique case (kind2)
      K_QNAN:  s_c = QNAN;
      K_INVAL: begin
        s_c   = QNAN;
        inv_c = 1'b1;
      end
      K_INF:   s_c = {sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      K_ZERO:  s_c = {sign2, {(W-1){1'b0}}};
      default: begin
        if (exp_r >= EXP_TOP) begin
          s_c   = {sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_c = 1'b1;
        end else if (exp_r <= EXP_LOW) begin
          s_c   = {sign2, {(W-1){1'b0}}};
          udf_c = 1'b1;
        end else begin
          s_c   = {sign2, exp_r[EXP_W-1:0], frac_r};
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control and output registers (reset)
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      s         <= '0;
      OUVERFLOW <= 1'b0;
      UNDERFLOW <= 1'b0;
      INVALID   <= 1'b0;
    end else if (advance) begin
      // advance implies in_ready, so in_valid alone marks an accept here.
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      // Bubbles present zero data and no flags.
      s         <= v2 ? s_c   : '0;
      OUVERFLOW <= v2 && ovf_c;
      UNDERFLOW <= v2 && udf_c;
      INVALID   <= v2 && inv_c;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers (no reset)
  // --------------------------------------------------------------------------
  // NOTE: datapath registers are left unreset; their contents only matter
  // when the matching valid bit is set, and that bit is reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      kind1  <= kind_c;
      sign1  <= sign_a ^ sign_b;
      exp_a1 <= exp_a;
      exp_b1 <= exp_b;
      man_a1 <= {1'b1, frac_a};
      man_b1 <= {1'b1, frac_b};

      kind2  <= kind1;
      sign2  <= sign1;
      exp2   <= $signed({2'b00, exp_a1}) + $signed({2'b00, exp_b1}) - BIAS;
      prod2  <= PW'(man_a1) * PW'(man_b1);
    end
  end

endmodule
